// File: rtl/parity_rx_pkg.sv
// Shared types and helpers for the parity-checking receiver: buffer state
// encoding, the expected-parity function and counter defaults.
package parity_rx_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_ERR_CNT_W  = 8;
    localparam int unsigned DEF_WORD_CNT_W = 16;

    // Saturation value of an error counter of the default width; the top
    // derives its own from its ERR_CNT_W the same way (all ones).
    localparam logic [DEF_ERR_CNT_W-1:0] DEF_ERR_SAT = '1;

    // Words up to 64 bits; the caller zero-extends, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rx_skid_buf.sv
// Two-entry buffer with valid/ready on both sides. Upstream ready depends on
// the state register alone; accept-with-pop in ONE replaces the head in place.
module rx_skid_buf
    import parity_rx_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid must not wait for ready.
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output buf_state_e   o_state
);

    buf_state_e r_state;
    buf_state_e w_state_nxt;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic w_in_ready;
    logic w_out_valid;
    logic w_load_head;
    logic w_shift;
    logic w_load_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_load_head = 1'b0;
        w_shift     = 1'b0;
        w_load_tail = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (i_valid) begin
                    w_state_nxt = ST_ONE;
                    w_load_head = 1'b1;
                end
            end
            ST_ONE: begin
                w_out_valid = 1'b1;
                if (i_valid && !i_ready) begin
                    w_state_nxt = ST_TWO;
                    w_load_tail = 1'b1;
                end else if (!i_valid && i_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else if (i_valid && i_ready) begin
                    w_load_head = 1'b1;
                end
            end
            ST_TWO: begin
                w_out_valid = 1'b1;
                w_in_ready  = 1'b0;
                if (i_ready) begin
                    w_state_nxt = ST_ONE;
                    w_shift     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= i_data;
            end else if (w_shift) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= i_data;
            end
        end
    end

    assign o_ready = w_in_ready;
    assign o_valid = w_out_valid;
    assign o_data  = r_head;
    assign o_state = r_state;

endmodule

// File: rtl/parity_check_rx.sv
// Receiver for the sum/parity link: checks each word's parity, tags or drops
// failing words, buffers them downstream and keeps error/word status counters.
module parity_check_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ERR_CNT_W   = DEF_ERR_CNT_W,
    parameter int WORD_CNT_W  = DEF_WORD_CNT_W,
    parameter int PARITY_ODD  = 0,
    parameter int DROP_ON_ERR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_parity,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_err,
    input  logic                  clr_err,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  err_sticky,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    localparam logic ODD  = (PARITY_ODD != 0);
    localparam logic DROP = (DROP_ON_ERR != 0);
    localparam logic [ERR_CNT_W-1:0] ERR_SAT = '1;

    logic w_exp_parity;
    logic w_bad;
    logic w_accept;
    logic w_bad_acc;
    logic w_push;
    logic w_buf_in_ready;
    logic w_buf_out_valid;
    logic [DATA_W:0] w_buf_in;
    logic [DATA_W:0] w_buf_out;
    buf_state_e w_buf_state;

    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic                  r_err_sticky;
    logic [WORD_CNT_W-1:0] r_word_cnt;

    assign w_exp_parity = calc_parity(64'(in_data), ODD);
    assign w_bad        = (w_exp_parity != in_parity);
    assign w_accept     = in_valid && w_buf_in_ready;
    assign w_bad_acc    = w_accept && w_bad;
    // A dropped word still counts as accepted but never reaches the buffer.
    assign w_push       = in_valid && !(DROP && w_bad);
    assign w_buf_in     = {w_bad && !DROP, in_data};

    rx_skid_buf #(
        .W(DATA_W + 1)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_push),
        .o_ready (w_buf_in_ready),
        .i_data  (w_buf_in),
        .o_valid (w_buf_out_valid),
        .i_ready (out_ready),
        .o_data  (w_buf_out),
        .o_state (w_buf_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            // A new error takes precedence over a simultaneous clear.
            if (w_bad_acc) begin
                r_err_sticky <= 1'b1;
                if (clr_err) begin
                    r_err_cnt <= ERR_CNT_W'(1);
                end else if (r_err_cnt != ERR_SAT) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else if (clr_err) begin
                r_err_cnt    <= '0;
                r_err_sticky <= 1'b0;
            end
        end
    end

    assign in_ready   = w_buf_in_ready;
    assign out_valid  = w_buf_out_valid;
    assign out_data   = w_buf_out[DATA_W-1:0];
    assign out_err    = w_buf_out[DATA_W];
    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;
    assign word_cnt   = r_word_cnt;

    a_src_hold: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_data) && $stable(in_parity)));

    a_ready_state: assert property (@(posedge clk) disable iff (rst)
        in_ready == (w_buf_state != ST_TWO));

endmodule

// File: tb/tb_parity_check_rx.sv
// Bench for parity_check_rx: a default instance and a 2-bit-counter drop-mode
// instance, each checked every cycle against a queue-based reference model.
module tb_parity_check_rx;

    logic clk;
    logic rst;

    logic       in_valid  [2];
    logic       in_parity [2];
    logic [7:0] in_data   [2];
    logic       out_ready [2];
    logic       clr_err   [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic [7:0] out_data  [2];
    logic       out_err   [2];
    logic       err_sticky[2];
    logic [15:0] word_cnt [2];
    logic [7:0] err_cnt0;
    logic [1:0] err_cnt1;

    logic [8:0] exp_q [2][$];
    int  m_err   [2];
    int  m_stick [2];
    int  m_wcnt  [2];
    bit  last_acc[2];

    int n_checks;
    int n_fail;

    parity_check_rx u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_parity(in_parity[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_err(out_err[0]),
        .clr_err(clr_err[0]), .err_cnt(err_cnt0),
        .err_sticky(err_sticky[0]), .word_cnt(word_cnt[0])
    );

    parity_check_rx #(
        .ERR_CNT_W(2),
        .DROP_ON_ERR(1)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_parity(in_parity[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_err(out_err[1]),
        .clr_err(clr_err[1]), .err_cnt(err_cnt1),
        .err_sticky(err_sticky[1]), .word_cnt(word_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_drop(int k);
        return (k == 1);
    endfunction

    function automatic int err_max(int k);
        return (k == 1) ? 3 : 255;
    endfunction

    function automatic logic [31:0] dut_err(int k);
        return (k == 0) ? {24'd0, err_cnt0} : {30'd0, err_cnt1};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int k, input logic v, input logic [7:0] d, input logic p);
        in_valid[k]  = v;
        in_data[k]   = d;
        in_parity[k] = p;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("in_ready[%0d]", k), in_ready[k], exp_q[k].size() < 2);
            check_val($sformatf("out_valid[%0d]", k), out_valid[k], exp_q[k].size() > 0);
            if (exp_q[k].size() > 0) begin
                check_val($sformatf("out_data[%0d]", k), out_data[k], exp_q[k][0][7:0]);
                check_val($sformatf("out_err[%0d]", k), out_err[k], exp_q[k][0][8]);
            end
            if (is_drop(k)) check_val($sformatf("out_err_drop[%0d]", k), out_err[k], 0);
            check_val($sformatf("err_cnt[%0d]", k), dut_err(k), m_err[k]);
            check_val($sformatf("err_sticky[%0d]", k), err_sticky[k], m_stick[k]);
            check_val($sformatf("word_cnt[%0d]", k), word_cnt[k], m_wcnt[k]);
        end
    endtask

    // One clock: sample inputs, advance the model on the edge, compare after.
    task automatic step();
        bit acc[2];
        bit pop[2];
        bit bad[2];
        bit clr[2];
        logic [7:0] d[2];
        bit r;
        r = rst;
        for (int k = 0; k < 2; k++) begin
            d[k]   = in_data[k];
            bad[k] = (($countones(in_data[k]) % 2) == 1) != in_parity[k];
            acc[k] = in_valid[k] && (exp_q[k].size() < 2);
            pop[k] = out_ready[k] && (exp_q[k].size() > 0);
            clr[k] = clr_err[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                exp_q[k].delete();
                m_err[k] = 0; m_stick[k] = 0; m_wcnt[k] = 0; last_acc[k] = 0;
            end else begin
                if (pop[k]) exp_q[k].delete(0);
                if (acc[k] && !(is_drop(k) && bad[k])) exp_q[k].push_back({bad[k], d[k]});
                if (acc[k]) m_wcnt[k] = (m_wcnt[k] + 1) % 65536;
                if (acc[k] && bad[k]) begin
                    m_stick[k] = 1;
                    if (clr[k]) m_err[k] = 1;
                    else if (m_err[k] < err_max(k)) m_err[k] = m_err[k] + 1;
                end else if (clr[k]) begin
                    m_err[k] = 0; m_stick[k] = 0;
                end
                last_acc[k] = acc[k];
            end
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            set_in(k, 1'b0, 8'h00, 1'b0);
            out_ready[k] = 1'b1;
            clr_err[k]   = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_in(k, 1'b0, 8'h00, 1'b0);
            out_ready[k] = 1'b1;
            clr_err[k]   = 1'b0;
            m_err[k] = 0; m_stick[k] = 0; m_wcnt[k] = 0; last_acc[k] = 0;
        end
        @(negedge clk);
        do_reset();
        check_val("rst_out_data0", out_data[0], 8'h00);
        check_val("rst_out_err0", out_err[0], 0);
        check_val("rst_in_ready1", in_ready[1], 1);

        // Good word 0x0B (three ones, parity 1).
        set_in(0, 1'b1, 8'h0B, 1'b1);
        step();
        set_in(0, 1'b0, 8'h00, 1'b0);
        check_val("good_data", out_data[0], 8'h0B);
        check_val("good_err", out_err[0], 0);
        check_val("good_wcnt", word_cnt[0], 1);
        step();

        // Bad word, then a lone clear.
        set_in(0, 1'b1, 8'h0B, 1'b0);
        step();
        set_in(0, 1'b0, 8'h00, 1'b0);
        check_val("bad_err", out_err[0], 1);
        check_val("bad_cnt", err_cnt0, 1);
        check_val("bad_sticky", err_sticky[0], 1);
        clr_err[0] = 1'b1;
        step();
        clr_err[0] = 1'b0;
        check_val("clr_cnt", err_cnt0, 0);
        check_val("clr_sticky", err_sticky[0], 0);

        // Backpressure: 0x01, 0x02 fill the buffer, 0x03 waits.
        do_reset();
        out_ready[0] = 1'b0;
        set_in(0, 1'b1, 8'h01, 1'b1);
        step();
        set_in(0, 1'b1, 8'h02, 1'b1);
        step();
        set_in(0, 1'b1, 8'h03, 1'b0);
        step();
        check_val("bp_full_ready", in_ready[0], 0);
        check_val("bp_head1", out_data[0], 8'h01);
        out_ready[0] = 1'b1;
        step();
        check_val("bp_head2", out_data[0], 8'h02);
        step();
        set_in(0, 1'b0, 8'h00, 1'b0);
        check_val("bp_head3", out_data[0], 8'h03);
        step();
        check_val("bp_empty", out_valid[0], 0);
        check_val("bp_wcnt", word_cnt[0], 3);

        // Saturation on the 2-bit counter, then clear colliding with an error.
        do_reset();
        set_in(1, 1'b1, 8'h0B, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check_val("sat_cnt", err_cnt1, 3);
        clr_err[1] = 1'b1;
        step();
        clr_err[1] = 1'b0;
        set_in(1, 1'b0, 8'h00, 1'b0);
        check_val("clr_win_cnt", err_cnt1, 1);
        check_val("clr_win_sticky", err_sticky[1], 1);

        // Drop mode: good, bad, good.
        do_reset();
        set_in(1, 1'b1, 8'h0A, 1'b0);
        step();
        check_val("drop_head_a", out_data[1], 8'h0A);
        set_in(1, 1'b1, 8'h0A, 1'b1);
        step();
        check_val("drop_gone", out_valid[1], 0);
        set_in(1, 1'b1, 8'h09, 1'b0);
        step();
        set_in(1, 1'b0, 8'h00, 1'b0);
        check_val("drop_head_9", out_data[1], 8'h09);
        check_val("drop_errcnt", err_cnt1, 1);
        check_val("drop_wcnt", word_cnt[1], 3);
        step();

        // Reset while the buffer is full.
        out_ready[0] = 1'b0;
        set_in(0, 1'b1, 8'h05, 1'b0);
        step();
        set_in(0, 1'b1, 8'h06, 1'b1);
        step();
        check_val("mid_full", in_ready[0], 0);
        do_reset();
        check_val("mid_valid", out_valid[0], 0);
        check_val("mid_ready", in_ready[0], 1);
        check_val("mid_wcnt", word_cnt[0], 0);
        set_in(0, 1'b1, 8'h12, 1'b0);
        step();
        set_in(0, 1'b0, 8'h00, 1'b0);
        check_val("mid_data", out_data[0], 8'h12);
        check_val("mid_err", out_err[0], 0);
        step();

        // Random traffic on both instances, holding unaccepted words.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(in_valid[k] && !last_acc[k])) begin
                    set_in(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                           1'($urandom_range(0, 1)));
                end
                out_ready[k] = ($urandom_range(0, 9) < 7);
                clr_err[k]   = ($urandom_range(0, 15) == 0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
